// File: rtl/kb_decoder.sv
// PS/2 keyboard decoder: frame receiver, scan-code FSM and event FIFO {ext, brk, code}.
// Build option: define KB_DECODER_MAKE_EN to also queue make (press) events with repeat filtering.

module ps2_rx (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ps2d,
  input  logic       i_ps2c,
  input  logic       i_rx_en,
  output logic       o_rx_done_tick,
  output logic [7:0] o_dout
);
  typedef enum logic [1:0] {RX_IDLE, RX_DPS, RX_LOAD} rx_state_t;

  rx_state_t  state_q, state_d;
  logic [7:0] filter_q, filter_d;
  logic       f_ps2c_q, f_ps2c_d;
  logic [3:0] n_q, n_d;
  logic [7:0] data_q, data_d;
  logic       fall_edge;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= RX_IDLE;
      filter_q <= '0;
      f_ps2c_q <= 1'b0;
      n_q      <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      f_ps2c_q <= f_ps2c_d;
      n_q      <= n_d;
      data_q   <= data_d;
    end
  end

  // PS/2 clock is only trusted after 8 consecutive identical samples
  always_comb begin
    filter_d = {i_ps2c, filter_q[7:1]};
    if (filter_q == '1)
      f_ps2c_d = 1'b1;
    else if (filter_q == '0)
      f_ps2c_d = 1'b0;
    else
      f_ps2c_d = f_ps2c_q;
    fall_edge = f_ps2c_q & ~f_ps2c_d;
  end

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    data_d         = data_q;
    o_rx_done_tick = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall_edge && i_rx_en) begin
          n_d     = 4'd9;
          state_d = RX_DPS;
        end
      end
      RX_DPS: begin
        if (fall_edge) begin
          // n = 9..2 are data bits LSB first; 1 is parity, 0 is stop
          if (n_q >= 4'd2)
            data_d = {i_ps2d, data_q[7:1]};
          if (n_q == 4'd0)
            state_d = RX_LOAD;
          else
            n_d = n_q - 4'd1;
        end
      end
      RX_LOAD: begin
        state_d        = RX_IDLE;
        o_rx_done_tick = 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_dout = data_q;
endmodule

module fifo #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_rd,
  input  logic         i_wr,
  input  logic [B-1:0] i_w_data,
  output logic         o_empty,
  output logic         o_full,
  output logic [B-1:0] o_r_data
);
  logic [B-1:0] mem_q [2**W];
  logic [W:0]   wr_ptr_q, rd_ptr_q;
  logic         wr_en, rd_en;

  // A write on a full FIFO is dropped even if a read happens in the same cycle
  assign wr_en = i_wr & ~o_full;
  assign rd_en = i_rd & ~o_empty;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < 2**W; i++)
        mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[W-1:0]] <= i_w_data;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en)
        rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign o_empty  = (wr_ptr_q == rd_ptr_q);
  assign o_full   = (wr_ptr_q[W] != rd_ptr_q[W]) && (wr_ptr_q[W-1:0] == rd_ptr_q[W-1:0]);
  assign o_r_data = mem_q[rd_ptr_q[W-1:0]];
endmodule

module kb_decoder #(
  parameter int unsigned FIFO_W     = 2,
  parameter int unsigned PAUSE_SKIP = 7
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ps2d,
  input  logic       i_ps2c,
  input  logic       i_rd_key,
  output logic [7:0] o_key_code,
  output logic       o_key_ext,
  output logic       o_key_brk,
  output logic       o_kb_buf_empty,
  output logic       o_kb_buf_full,
  output logic       o_overflow_tick
);
  localparam int unsigned SKIP_W = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t            state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              rx_done;
  logic [7:0]        rx_byte;
  logic              ev_vld, ev_ext, ev_brk;
  logic              wr_req;
  logic [9:0]        fifo_rdata;

  ps2_rx u_rx (
    .i_clk          (i_clk),
    .i_reset        (~i_reset_n),
    .i_ps2d         (i_ps2d),
    .i_ps2c         (i_ps2c),
    .i_rx_en        (1'b1),
    .o_rx_done_tick (rx_done),
    .o_dout         (rx_byte)
  );

  fifo #(.B(10), .W(FIFO_W)) u_fifo (
    .i_clk    (i_clk),
    .i_reset  (~i_reset_n),
    .i_rd     (i_rd_key),
    .i_wr     (wr_req),
    .i_w_data ({ev_ext, ev_brk, rx_byte}),
    .o_empty  (o_kb_buf_empty),
    .o_full   (o_kb_buf_full),
    .o_r_data (fifo_rdata)
  );

  assign {o_key_ext, o_key_brk, o_key_code} = fifo_rdata;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    ev_vld  = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (rx_done) begin
      case (state_q)
        IDLE: begin
          case (rx_byte)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = SKIP;
              skip_d  = SKIP_W'(PAUSE_SKIP);
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            default: ev_vld = 1'b1;
          endcase
        end
        EXT: begin
          case (rx_byte)
            8'hF0: state_d = EXT_BRK;
            8'hE0, 8'h12: ;
            default: begin
              ev_vld  = 1'b1;
              ev_ext  = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
        BRK: begin
          ev_vld  = 1'b1;
          ev_brk  = 1'b1;
          state_d = IDLE;
        end
        EXT_BRK: begin
          if (rx_byte != 8'h12) begin
            ev_vld = 1'b1;
            ev_ext = 1'b1;
            ev_brk = 1'b1;
          end
          state_d = IDLE;
        end
        SKIP: begin
          skip_d = (skip_q == '0) ? '0 : skip_q - SKIP_W'(1);
          if (skip_q <= SKIP_W'(1))
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef KB_DECODER_MAKE_EN
  logic [8:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
  logic       repeat_hit;

  always_comb begin
    repeat_hit = last_vld_q && (last_q == {ev_ext, rx_byte});
    wr_req     = ev_vld && (ev_brk || !repeat_hit);
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (ev_vld && !ev_brk && wr_req && !o_kb_buf_full) begin
      last_d     = {ev_ext, rx_byte};
      last_vld_d = 1'b1;
    end else if (ev_vld && ev_brk && repeat_hit) begin
      last_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign wr_req = ev_vld && ev_brk;
`endif

  assign o_overflow_tick = wr_req & o_kb_buf_full;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end
endmodule

// File: doc/kb_decoder.md
KB_DECODER -- requirements
Module: kb_decoder

Interface
REQ-001 SHALL have parameter FIFO_W, default 2, meaning the event FIFO holds 2^FIFO_W entries.
REQ-002 SHALL have parameter PAUSE_SKIP, default 7, meaning the number of bytes discarded after an E1 prefix.
REQ-003 i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 i_reset_n  input  1  asynchronous active-low reset.
REQ-005 i_ps2d, i_ps2c  input  1 each  raw PS/2 data and clock lines.
REQ-006 i_rd_key  input  1  pop request; removes the head FIFO entry.
REQ-007 o_key_code  output  8  scan code of the head FIFO entry.
REQ-008 o_key_ext  output  1  head entry carried the E0 prefix.
REQ-009 o_key_brk  output  1  head entry is a release (1) or a press (0).
REQ-010 o_kb_buf_empty, o_kb_buf_full  output  1 each  FIFO status.
REQ-011 o_overflow_tick  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-012 SHALL instantiate ps2_rx with i_rx_en tied to 1, and FIFO with B=10 and W=FIFO_W; the FIFO word is {ext, brk, code[7:0]}.
REQ-013 SHALL drive both submodule resets with ~i_reset_n.
REQ-014 The FSM SHALL have exactly five states: IDLE, EXT, BRK, EXT_BRK and SKIP. All transitions SHALL occur only on a cycle where the receiver done tick is high.
REQ-015 IDLE transitions:
- E0 -> EXT
- F0 -> BRK
- E1 -> SKIP, with the skip counter loaded to PAUSE_SKIP
- AA, FA, FE, EE, 00, FF -> ignored, stay in IDLE
- any other byte -> make event {0,0,byte}, stay in IDLE
REQ-016 EXT transitions:
- F0 -> EXT_BRK
- E0 or 12 -> ignored, stay in EXT (fake-shift filter)
- any other byte -> make event {1,0,byte}, go to IDLE
REQ-017 BRK transitions: any byte -> break event {0,1,byte}, go to IDLE.
REQ-018 EXT_BRK transitions:
- 12 -> no event, go to IDLE
- any other byte -> break event {1,1,byte}, go to IDLE
REQ-019 SKIP SHALL decrement the counter on each byte and return to IDLE after the byte that takes the counter to 0; no events are generated in SKIP.
REQ-020 Event write rules:
- an event SHALL be written to the FIFO combinationally, in the same cycle as the done tick
- o_kb_buf_empty SHALL fall on the following clock edge
REQ-021 If the FIFO is full when an event is generated, the event SHALL be dropped, o_overflow_tick SHALL pulse for that cycle, and the state transition SHALL still occur.
REQ-022 Repeat filter for make events:
- a 9-bit last-make register {ext,code} with a valid flag SHALL be kept
- a make event equal to the valid last-make SHALL not be written
- a written make SHALL load the register and set the valid flag
- a break event whose {ext,code} equals the register SHALL clear the valid flag
REQ-023 Simultaneous i_rd_key and event write on a full FIFO SHALL follow the FIFO's write-when-full rule; the event SHALL be counted as dropped, and o_overflow_tick SHALL pulse.
REQ-024 i_rd_key while the FIFO is empty SHALL have no effect.

Reset
REQ-025 While i_reset_n=0, the block SHALL hold:
- state = IDLE, skip counter = 0, last-make valid flag = 0
- FIFO empty: o_kb_buf_empty=1, o_kb_buf_full=0
- o_overflow_tick=0
- o_key_code, o_key_ext and o_key_brk as the FIFO presents when empty
REQ-026 Reset asserted mid-sequence (for example between E0 and the code byte) SHALL discard the partial sequence; the next byte after release SHALL be decoded from IDLE.

Configuration
REQ-027 Macro KB_DECODER_MAKE_EN:
- when defined, make events SHALL be written per REQ-015, REQ-016 and REQ-022
- when undefined, make events SHALL never be written, the repeat-filter logic SHALL be absent, and only break events SHALL reach the FIFO (release-only behaviour)

Verification
REQ-028 Frames 1C, F0, 1C -> with MAKE_EN: entries {0,0,1C} then {0,1,1C}; without MAKE_EN: only {0,1,1C}.
REQ-029 Frames E0, 75, E0, F0, 75 -> with MAKE_EN: entries {1,0,75} then {1,1,75}; E0, F0, 12 -> no entry.
REQ-030 Frames 1C, 1C, 1C, F0, 1C, 1C -> with MAKE_EN: entries {0,0,1C}, {0,1,1C}, {0,0,1C} (the repeats are filtered).
REQ-031 Pause sequence E1, 14, 77, E1, F0, 14, F0, 77, then 29 -> the only entry is {0,0,29} (with MAKE_EN).
REQ-032 FIFO_W=2, five break events with no reads -> four entries, o_kb_buf_full=1, one o_overflow_tick pulse; four i_rd_key pops return the events in order, then o_kb_buf_empty=1.
REQ-033 Frame E0, then i_reset_n low for 2 cycles, then frames F0, 1C -> a single entry {0,1,1C}.
